// File: rtl/vscale_mul_div_iter.sv
// rtl/vscale_mul_div_iter.sv - iterative RV32M/RV64M multiply/divide unit
// Retires BITS_PER_CYCLE result bits per compute cycle on operand magnitudes, sign fixed up in SETUP.
module vscale_mul_div_iter #(
    parameter int XLEN           = 32,
    parameter int BITS_PER_CYCLE = 1,
    parameter int TAG_W          = 5
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             req_valid,
    output logic             req_ready,
    input  logic [2:0]       req_funct3,
    input  logic [TAG_W-1:0] req_tag,
    input  logic [XLEN-1:0]  req_in_1,
    input  logic [XLEN-1:0]  req_in_2,
    input  logic             kill,
    output logic             resp_valid,
    input  logic             resp_ready,
    output logic [XLEN-1:0]  resp_result,
    output logic [TAG_W-1:0] resp_tag,
    output logic             busy
);

    localparam int N  = XLEN / BITS_PER_CYCLE;
    localparam int CW = $clog2(N) + 1;

    typedef enum logic [1:0] {IDLE, COMPUTE, SETUP, DONE} state_t;

    state_t            state, state_next;
    logic [2:0]        funct3_q;
    logic              neg_q;
    logic [XLEN-1:0]   op_a, op_b;
    logic [XLEN-1:0]   acc_hi, acc_lo;
    logic [CW-1:0]     cnt;

    logic              sign_1_op, sign_2_op, s1, s2, neg_in;
    logic              div_zero, div_ovf, fast;
    logic [XLEN-1:0]   mag_1, mag_2, fast_result;
    logic              accept;

    logic [XLEN-1:0]   step_hi, step_lo;
    logic [XLEN:0]     step_t;
    logic [2*XLEN-1:0] prod_s;
    logic [XLEN-1:0]   quo_s, rem_s, setup_result;

    assign accept = req_valid && req_ready;

    always_comb begin
        sign_1_op   = (req_funct3 == 3'd1) || (req_funct3 == 3'd2) ||
                      (req_funct3 == 3'd4) || (req_funct3 == 3'd6);
        sign_2_op   = (req_funct3 == 3'd1) || (req_funct3 == 3'd4) || (req_funct3 == 3'd6);
        s1          = sign_1_op && req_in_1[XLEN-1];
        s2          = sign_2_op && req_in_2[XLEN-1];
        mag_1       = s1 ? -req_in_1 : req_in_1;
        mag_2       = s2 ? -req_in_2 : req_in_2;
        // REM takes the dividend's sign; unsigned ops have s1 = s2 = 0
        neg_in      = (req_funct3 == 3'd6) ? s1 : (s1 ^ s2);
        div_zero    = req_funct3[2] && (req_in_2 == '0);
        div_ovf     = ((req_funct3 == 3'd4) || (req_funct3 == 3'd6)) &&
                      (req_in_1 == {1'b1, {(XLEN-1){1'b0}}}) && (req_in_2 == '1);
        fast        = div_zero || div_ovf;
        fast_result = '0;
        if (div_zero)
            fast_result = req_funct3[1] ? req_in_1 : '1;
        else
            fast_result = req_funct3[1] ? '0 : req_in_1;
    end

    // hi:lo is the product accumulator (LSB-first) or remainder:quotient (MSB-first)
    always_comb begin
        step_hi = acc_hi;
        step_lo = acc_lo;
        step_t  = '0;
        for (int i = 0; i < BITS_PER_CYCLE; i++) begin
            if (funct3_q[2]) begin
                step_t  = {step_hi, step_lo[XLEN-1]};
                step_lo = {step_lo[XLEN-2:0], 1'b0};
                if (step_t >= {1'b0, op_b}) begin
                    step_t     = step_t - {1'b0, op_b};
                    step_lo[0] = 1'b1;
                end
                step_hi = step_t[XLEN-1:0];
            end else begin
                step_t  = {1'b0, step_hi} + (step_lo[0] ? {1'b0, op_a} : '0);
                step_lo = {step_t[0], step_lo[XLEN-1:1]};
                step_hi = step_t[XLEN:1];
            end
        end
    end

    always_comb begin
        prod_s = neg_q ? -{acc_hi, acc_lo} : {acc_hi, acc_lo};
        quo_s  = neg_q ? -acc_lo : acc_lo;
        rem_s  = neg_q ? -acc_hi : acc_hi;
        case (funct3_q)
            3'd0:                   setup_result = prod_s[XLEN-1:0];
            3'd1, 3'd2, 3'd3:       setup_result = prod_s[2*XLEN-1:XLEN];
            3'd4, 3'd5:             setup_result = quo_s;
            default:                setup_result = rem_s;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) state <= IDLE;
        else       state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (accept) state_next = fast ? DONE : COMPUTE;
            COMPUTE: if (kill) state_next = IDLE;
                     else if (cnt == '0) state_next = SETUP;
            SETUP:   state_next = kill ? IDLE : DONE;
            DONE:    if (kill || resp_ready) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        req_ready  = (state == IDLE) && !kill;
        resp_valid = (state == DONE) && !kill;
        busy       = (state != IDLE);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            funct3_q    <= '0;
            neg_q       <= 1'b0;
            op_a        <= '0;
            op_b        <= '0;
            acc_hi      <= '0;
            acc_lo      <= '0;
            cnt         <= '0;
            resp_result <= '0;
            resp_tag    <= '0;
        end else begin
            if (accept) begin
                funct3_q <= req_funct3;
                neg_q    <= neg_in;
                op_a     <= mag_1;
                op_b     <= mag_2;
                acc_hi   <= '0;
                acc_lo   <= req_funct3[2] ? mag_1 : mag_2;
                cnt      <= CW'(N - 1);
                resp_tag <= req_tag;
                if (fast) resp_result <= fast_result;
            end
            if (state == COMPUTE) begin
                acc_hi <= step_hi;
                acc_lo <= step_lo;
                cnt    <= cnt - 1'b1;
            end
            if (state == SETUP) resp_result <= setup_result;
        end
    end

endmodule

// File: tb/tb_vscale_mul_div_iter.sv
// tb/tb_vscale_mul_div_iter.sv - directed-vector bench over three parameter sets of vscale_mul_div_iter
module tb_vscale_mul_div_iter;

    logic        clk, reset;
    logic        req_valid, kill, resp_ready;
    logic [2:0]  f3;
    logic [4:0]  tag, tag_ctr;
    logic [63:0] in_1, in_2;
    int          sel;

    logic        rr0, rr1, rr2, rv0, rv1, rv2, bz0, bz1, bz2;
    logic [31:0] res0, res1;
    logic [63:0] res2;
    logic [4:0]  tg0, tg1, tg2;

    logic        m_rr, m_rv, m_bz;
    logic [63:0] m_res;
    logic [4:0]  m_tag;

    int n_vec = 0, n_bad = 0, hs = 0;

    vscale_mul_div_iter #(.XLEN(32), .BITS_PER_CYCLE(1), .TAG_W(5)) u_d0 (
        .clk(clk), .reset(reset), .req_valid(req_valid && sel == 0), .req_ready(rr0),
        .req_funct3(f3), .req_tag(tag), .req_in_1(in_1[31:0]), .req_in_2(in_2[31:0]),
        .kill(kill), .resp_valid(rv0), .resp_ready(resp_ready), .resp_result(res0),
        .resp_tag(tg0), .busy(bz0));

    vscale_mul_div_iter #(.XLEN(32), .BITS_PER_CYCLE(4), .TAG_W(5)) u_d1 (
        .clk(clk), .reset(reset), .req_valid(req_valid && sel == 1), .req_ready(rr1),
        .req_funct3(f3), .req_tag(tag), .req_in_1(in_1[31:0]), .req_in_2(in_2[31:0]),
        .kill(kill), .resp_valid(rv1), .resp_ready(resp_ready), .resp_result(res1),
        .resp_tag(tg1), .busy(bz1));

    vscale_mul_div_iter #(.XLEN(64), .BITS_PER_CYCLE(1), .TAG_W(5)) u_d2 (
        .clk(clk), .reset(reset), .req_valid(req_valid && sel == 2), .req_ready(rr2),
        .req_funct3(f3), .req_tag(tag), .req_in_1(in_1), .req_in_2(in_2),
        .kill(kill), .resp_valid(rv2), .resp_ready(resp_ready), .resp_result(res2),
        .resp_tag(tg2), .busy(bz2));

    always_comb begin
        case (sel)
            0:       begin m_rr = rr0; m_rv = rv0; m_bz = bz0; m_res = {32'b0, res0}; m_tag = tg0; end
            1:       begin m_rr = rr1; m_rv = rv1; m_bz = bz1; m_res = {32'b0, res1}; m_tag = tg1; end
            default: begin m_rr = rr2; m_rv = rv2; m_bz = bz2; m_res = res2;          m_tag = tg2; end
        endcase
    end

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) if (!reset && m_rv && resp_ready) hs++;

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", name, got, exp);
        end
    endtask

    // Returns at the falling edge of the first resp_valid cycle; completes the handshake if resp_ready.
    task automatic do_op(input string name, input logic [2:0] fn, input logic [63:0] a,
                         input logic [63:0] b, input logic [63:0] exp, input int lat,
                         input bit now = 1'b0);
        int  cyc;
        bit  seen;
        logic [4:0] etag;
        if (!now) begin @(posedge clk); #1; end
        f3 = fn; in_1 = a; in_2 = b; tag = tag_ctr; etag = tag_ctr; tag_ctr = tag_ctr + 5'd1;
        req_valid = 1'b1;
        if (!now) @(negedge clk);
        check({name, "/req_ready"}, 64'(m_rr), 64'd1);
        @(posedge clk); #1;
        req_valid = 1'b0;
        cyc = 1; seen = 1'b0;
        while (!seen && cyc <= 200) begin
            @(negedge clk);
            if (m_rv) seen = 1'b1;
            else begin @(posedge clk); cyc++; end
        end
        check({name, "/latency"}, 64'(cyc), 64'(lat));
        check({name, "/result"}, m_res, exp);
        check({name, "/tag"}, 64'(m_tag), 64'(etag));
        if (resp_ready) begin
            @(posedge clk); @(negedge clk);
            check({name, "/idle_after"}, 64'(m_bz), 64'd0);
        end
    endtask

    task automatic run_list32(input int lat);
        do_op("mul_7_m3",   3'd0, 64'h7,        64'hFFFFFFFD, 64'hFFFFFFEB, lat);
        do_op("mulh_min2",  3'd1, 64'h80000000, 64'h80000000, 64'h40000000, lat);
        do_op("mulhu_ones", 3'd3, 64'hFFFFFFFF, 64'hFFFFFFFF, 64'hFFFFFFFE, lat);
        do_op("mulhsu",     3'd2, 64'hFFFFFFFF, 64'hFFFFFFFF, 64'hFFFFFFFF, lat);
        do_op("mulh_m3_7",  3'd1, 64'hFFFFFFFD, 64'h7,        64'hFFFFFFFF, lat);
        do_op("div_m7_2",   3'd4, 64'hFFFFFFF9, 64'h2,        64'hFFFFFFFD, lat);
        do_op("rem_m7_2",   3'd6, 64'hFFFFFFF9, 64'h2,        64'hFFFFFFFF, lat);
        do_op("div_7_m2",   3'd4, 64'h7,        64'hFFFFFFFE, 64'hFFFFFFFD, lat);
        do_op("rem_7_m2",   3'd6, 64'h7,        64'hFFFFFFFE, 64'h1,        lat);
        do_op("divu_100_7", 3'd5, 64'd100,      64'd7,        64'd14,       lat);
        do_op("remu_100_7", 3'd7, 64'd100,      64'd7,        64'd2,        lat);
        do_op("div_by0",    3'd4, 64'd5,        64'd0,        64'hFFFFFFFF, 1);
        do_op("remu_by0",   3'd7, 64'd5,        64'd0,        64'd5,        1);
        do_op("div_ovf",    3'd4, 64'h80000000, 64'hFFFFFFFF, 64'h80000000, 1);
        do_op("rem_ovf",    3'd6, 64'h80000000, 64'hFFFFFFFF, 64'h0,        1);
    endtask

    task automatic run_ctl32(input int lat);
        int h0, nv;
        // backpressure: DONE held for 10 cycles
        resp_ready = 1'b0;
        do_op("bp_mul", 3'd0, 64'h7, 64'hFFFFFFFD, 64'hFFFFFFEB, lat);
        for (int i = 0; i < 10; i++) begin
            @(posedge clk); @(negedge clk);
            check("bp_valid", 64'(m_rv), 64'd1);
            check("bp_result", m_res, 64'hFFFFFFEB);
            check("bp_req_ready", 64'(m_rr), 64'd0);
        end
        resp_ready = 1'b1;
        @(posedge clk); @(negedge clk);
        check("bp_ready_after", 64'(m_rr), 64'd1);
        do_op("bp_next", 3'd5, 64'd100, 64'd7, 64'd14, lat, 1'b1);
        // kill in cycle 5 of COMPUTE
        @(posedge clk); #1;
        f3 = 3'd5; in_1 = 64'd100; in_2 = 64'd7; req_valid = 1'b1;
        @(posedge clk); #1;
        req_valid = 1'b0;
        repeat (4) @(posedge clk);
        #1 kill = 1'b1;
        @(posedge clk); #1 kill = 1'b0;
        @(negedge clk);
        check("kill_req_ready", 64'(m_rr), 64'd1);
        check("kill_busy", 64'(m_bz), 64'd0);
        nv = 0;
        repeat (80) begin @(negedge clk); if (m_rv) nv++; end
        check("kill_no_resp", 64'(nv), 64'd0);
        do_op("kill_then_mul", 3'd0, 64'd3, 64'd4, 64'd12, lat);
        // kill together with resp_ready in DONE
        resp_ready = 1'b0;
        do_op("kd_mul", 3'd0, 64'd3, 64'd4, 64'd12, lat);
        h0 = hs;
        kill = 1'b1; resp_ready = 1'b1;
        #1 check("kd_valid_masked", 64'(m_rv), 64'd0);
        @(posedge clk); #1 kill = 1'b0;
        @(negedge clk);
        check("kd_busy", 64'(m_bz), 64'd0);
        check("kd_no_handshake", 64'(hs), 64'(h0));
        // kill in IDLE suppresses acceptance
        @(posedge clk); #1;
        kill = 1'b1; req_valid = 1'b1; f3 = 3'd0; in_1 = 64'd3; in_2 = 64'd4;
        @(negedge clk);
        check("ki_req_ready", 64'(m_rr), 64'd0);
        @(posedge clk); #1 kill = 1'b0; req_valid = 1'b0;
        @(negedge clk);
        check("ki_busy", 64'(m_bz), 64'd0);
    endtask

    initial begin
        reset = 1'b1; req_valid = 1'b0; kill = 1'b0; resp_ready = 1'b1;
        f3 = 3'd0; tag = 5'd0; tag_ctr = 5'd3; in_1 = '0; in_2 = '0; sel = 0;
        repeat (3) @(posedge clk);
        #1 reset = 1'b0;
        @(negedge clk);
        check("rst_resp_valid", 64'(m_rv), 64'd0);
        check("rst_busy", 64'(m_bz), 64'd0);
        check("rst_result", m_res, 64'd0);
        check("rst_tag", 64'(m_tag), 64'd0);
        check("rst_req_ready", 64'(m_rr), 64'd1);

        for (int s = 0; s < 2; s++) begin
            sel = s;
            run_list32(s == 0 ? 34 : 10);
            run_ctl32(s == 0 ? 34 : 10);
        end

        sel = 2;
        do_op("x64_mul",   3'd0, 64'h7, 64'hFFFFFFFFFFFFFFFD, 64'hFFFFFFFFFFFFFFEB, 66);
        do_op("x64_mulhu", 3'd3, 64'hFFFFFFFFFFFFFFFF, 64'hFFFFFFFFFFFFFFFF, 64'hFFFFFFFFFFFFFFFE, 66);
        do_op("x64_mulh",  3'd1, 64'h8000000000000000, 64'h8000000000000000, 64'h4000000000000000, 66);
        do_op("x64_div",   3'd4, 64'hFFFFFFFFFFFFFFF9, 64'h2, 64'hFFFFFFFFFFFFFFFD, 66);
        do_op("x64_remu",  3'd7, 64'd100, 64'd7, 64'd2, 66);
        do_op("x64_ovf",   3'd4, 64'h8000000000000000, 64'hFFFFFFFFFFFFFFFF, 64'h8000000000000000, 1);
        do_op("x64_by0",   3'd7, 64'd5, 64'd0, 64'd5, 1);

        // reset in the middle of an operation abandons it
        @(posedge clk); #1;
        f3 = 3'd3; in_1 = '1; in_2 = '1; req_valid = 1'b1;
        @(posedge clk); #1 req_valid = 1'b0;
        repeat (5) @(posedge clk);
        #1 reset = 1'b1;
        @(posedge clk); #1 reset = 1'b0;
        @(negedge clk);
        check("mid_rst_busy", 64'(m_bz), 64'd0);
        check("mid_rst_valid", 64'(m_rv), 64'd0);
        check("mid_rst_result", m_res, 64'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
